seg_display_scan: RTL

Downstream consumer of the hour/minute/second modulo counters. Takes their 8-bit binary counts and converts each field to two BCD digits. Time-multiplexes six common-anode 7-segment digits (HH MM SS) on the board. Supports per-field blinking for time-set mode and a colon indicator driven by the decimal points.

---
 rtl/seg_display_scan_pkg.sv | 44 ++++
 rtl/seg_display_scan_if.sv | 19 +
 rtl/seg_display_scan_bin2bcd99.sv | 26 ++
 rtl/seg_display_scan.sv | 108 ++++++++++
 4 files changed

// File: rtl/seg_display_scan_pkg.sv
// seg_pkg: shared constants for the six-digit HH MM SS scanner.
//   NUM_DIGITS / NUM_FIELDS  - display geometry (two digits per field)
//   SEG_0..SEG_9, SEG_DASH   - active-low a..g codes (bit0=a .. bit6=g)
//   SEG_BLANK                - all eight segments (incl. dp) off
//   FLD_SEC/FLD_MIN/FLD_HOUR - field index; field = digit_idx / 2
//   seg_encode()             - BCD digit to active-low a..g code
package seg_pkg;
  localparam int NUM_DIGITS = 6;
  localparam int NUM_FIELDS = 3;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int FLD_SEC  = 0;
  localparam int FLD_MIN  = 1;
  localparam int FLD_HOUR = 2;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = SEG_0;
      4'd1:    seg_encode = SEG_1;
      4'd2:    seg_encode = SEG_2;
      4'd3:    seg_encode = SEG_3;
      4'd4:    seg_encode = SEG_4;
      4'd5:    seg_encode = SEG_5;
      4'd6:    seg_encode = SEG_6;
      4'd7:    seg_encode = SEG_7;
      4'd8:    seg_encode = SEG_8;
      4'd9:    seg_encode = SEG_9;
      default: seg_encode = SEG_DASH;
    endcase
  endfunction
endpackage

// File: rtl/seg_display_scan_if.sv
// seg_display_scan_if: time fields and display drive between the clock
// counters (master) and the display scanner (slave).
//   hour/min/sec [7:0] - binary counts, valid 0..99
//   blink [2:0]        - per-field blink enable ([2]=hour,[1]=min,[0]=sec)
//   colon_on           - light the separator decimal points
//   an [5:0]           - active-low digit enables, an[0]=sec ones
//   seg [7:0]          - active-low segments, seg[7]=dp
interface seg_display_scan_if;
  logic [7:0] hour;
  logic [7:0] min;
  logic [7:0] sec;
  logic [2:0] blink;
  logic       colon_on;
  logic [5:0] an;
  logic [7:0] seg;

  modport master (output hour, min, sec, blink, colon_on, input an, seg);
  modport slave  (input hour, min, sec, blink, colon_on, output an, seg);
endinterface

// File: rtl/seg_display_scan_bin2bcd99.sv
// bin2bcd99: combinational 8-bit binary to two BCD digits.
//   bin [7:0]  - binary value
//   tens [3:0] - bin / 10 (0 when ovf)
//   ones [3:0] - bin % 10 (0 when ovf)
//   ovf        - bin > 99
module bin2bcd99
  import seg_pkg::*;
(
  input  logic [7:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       ovf
);
  logic [3:0] t;

  always_comb begin
    t = '0;
    for (int i = 1; i < 10; i++)
      if (bin >= 8'(10 * i)) t = 4'(i);
    ovf  = bin > 8'd99;
    tens = ovf ? 4'd0 : t;
    // The true remainder is < 10, so its low nibble is exact under
    // 4-bit wrap-around arithmetic.
    ones = ovf ? 4'd0 : bin[3:0] - 4'(t * 4'd10);
  end
endmodule

// File: rtl/seg_display_scan.sv
// seg_display_scan: time-multiplexed driver for six common-anode digits
// showing HH MM SS. Fields are snapshotted once per scan frame so a frame
// never tears; blink and colon act live.
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - seg_display_scan_if.slave (time fields in, an/seg out)
// Params: SCAN_DIV clocks per digit (>=2), BLINK_FRAMES frames per blink
// phase (>=1).
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic               clk,
  input  logic               reset,
  seg_display_scan_if.slave  bus
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]                 div_cnt_q, div_cnt_d;
  logic [2:0]                       digit_idx_q, digit_idx_d;
  logic [FRM_W-1:0]                 frame_cnt_q, frame_cnt_d;
  logic                             blink_ph_q, blink_ph_d;
  logic [NUM_FIELDS-1:0][7:0]       snap_q, snap_d;
  logic [NUM_DIGITS-1:0]            an_q, an_d;
  logic [7:0]                       seg_q, seg_d;

  logic [NUM_FIELDS-1:0][7:0]       live;
  logic [NUM_FIELDS-1:0][3:0]       tens, ones;
  logic [NUM_FIELDS-1:0]            ovf;
  logic                             div_last, frame_wrap;
  logic [1:0]                       fld;
  logic [3:0]                       bcd;
  logic [6:0]                       code;
  logic                             dp_n;

  assign live = {bus.hour, bus.min, bus.sec};

  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_fld
    bin2bcd99 u_b2b (
      .bin  (snap_q[f]),
      .tens (tens[f]),
      .ones (ones[f]),
      .ovf  (ovf[f])
    );
  end

  // Scan timing, frame snapshot and blink phase.
  always_comb begin
    div_last    = div_cnt_q == DIV_LAST;
    frame_wrap  = div_last && (digit_idx_q == IDX_LAST);
    div_cnt_d   = div_last ? '0 : div_cnt_q + DIV_W'(1);
    digit_idx_d = digit_idx_q;
    frame_cnt_d = frame_cnt_q;
    blink_ph_d  = blink_ph_q;
    snap_d      = snap_q;
    if (div_last)
      digit_idx_d = frame_wrap ? 3'd0 : digit_idx_q + 3'd1;
    if (frame_wrap) begin
      snap_d = live;
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FRM_W'(1);
      end
    end
  end

  // Digit decode; two digits per field so the field is idx/2 and the
  // odd digit of each pair is the tens digit.
  always_comb begin
    fld  = digit_idx_q[2:1];
    bcd  = digit_idx_q[0] ? tens[fld] : ones[fld];
    code = ovf[fld] ? SEG_DASH : seg_encode(bcd);
    dp_n = ~(bus.colon_on && (digit_idx_q == 3'd2 || digit_idx_q == 3'd4));
    seg_d = (bus.blink[fld] && blink_ph_q) ? SEG_BLANK : {dp_n, code};
    an_d  = ~(NUM_DIGITS'(1) << digit_idx_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q   <= '0;
      digit_idx_q <= '0;
      frame_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      snap_q      <= '0;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
    end else begin
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      frame_cnt_q <= frame_cnt_d;
      blink_ph_q  <= blink_ph_d;
      snap_q      <= snap_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
endmodule
